// File: rtl/jt95c061_pkg.sv
// jt95c061_pkg: SFR offsets, prescaler tap positions and FF command codes for the 95C061 timers
package jt95c061_pkg;
  localparam logic [3:0] TRUN_A   = 4'h0;
  localparam logic [3:0] TREG0_A  = 4'h2;
  localparam logic [3:0] TREG1_A  = 4'h3;
  localparam logic [3:0] T01MOD_A = 4'h4;
  localparam logic [3:0] TFFCR_A  = 4'h5;
  localparam logic [3:0] TREG2_A  = 4'h6;
  localparam logic [3:0] TREG3_A  = 4'h7;
  localparam logic [3:0] T23MOD_A = 4'h8;
  localparam int PT1_B   = 2;
  localparam int PT4_B   = 4;
  localparam int PT16_B  = 6;
  localparam int PT256_B = 10;
  localparam logic [1:0] FF_NONE = 2'b11;
endpackage

// File: rtl/jt95c061_prescaler.sv
// jt95c061_prescaler: free-running phi divider with fixed taps, cleared while disabled
module jt95c061_prescaler
  import jt95c061_pkg::*;
#(
  parameter int PRE_W = 11
) (
  input  logic rst,
  input  logic clk,
  input  logic cen,
  input  logic halt,
  input  logic en,
  output logic pt1,
  output logic pt4,
  output logic pt16,
  output logic pt256
);
  logic [PRE_W-1:0] pre;
  logic unused_pre;
  always_ff @(posedge clk or posedge rst)
    if (rst) pre <= '0;
    else if (!en) pre <= '0;
    else if (cen && !halt) pre <= pre + 1'b1;
  assign pt1   = pre[PT1_B];
  assign pt4   = pre[PT4_B];
  assign pt16  = pre[PT16_B];
  assign pt256 = pre[PT256_B];
  assign unused_pre = ^pre;
endmodule

// File: rtl/jt95c061_tmr_ctrl.sv
// jt95c061_tmr_ctrl: timer 0..3 control registers, prescaler and FF command pulses.
// JT95C061_TREG_DBUF_EN adds double buffering of TREG0/TREG2 via T01MOD[4]/T23MOD[4].
module jt95c061_tmr_ctrl
  import jt95c061_pkg::*;
#(
  parameter int PRE_W = 11
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        cen,
  input  logic        halt,
  input  logic        cs,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic        tin0,
  input  logic        tin2,
  input  logic [3:0]  over,
  output logic [15:0] muxin,
  output logic [7:0]  muxsel,
  output logic [31:0] cntmax,
  output logic [3:0]  run,
  output logic [3:0]  ffc1,
  output logic [3:0]  ffc3
);
  logic [7:0] trun, t01mod, t23mod, treg0, treg1, treg2, treg3, treg0_rd, treg2_rd;
  logic [3:0] ffcr;
  logic [1:0] cmd1, cmd3;
  logic pt1, pt4, pt16, pt256, wr, unused_over;
  assign wr = cs & we;
  assign unused_over = over[1] ^ over[3];
  jt95c061_prescaler #(.PRE_W(PRE_W)) u_pre (
    .rst(rst), .clk(clk), .cen(cen), .halt(halt), .en(trun[7]),
    .pt1(pt1), .pt4(pt4), .pt16(pt16), .pt256(pt256)
  );
  // cmd fields live only as a pending pulse; they fall back to "none" on the next non-halt cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      trun <= '0;
      t01mod <= '0;
      t23mod <= '0;
      treg1 <= '0;
      treg3 <= '0;
      ffcr <= '0;
      cmd1 <= FF_NONE;
      cmd3 <= FF_NONE;
    end else begin
      if (!halt) begin
        cmd1 <= FF_NONE;
        cmd3 <= FF_NONE;
      end
      if (wr)
        case (addr)
          TRUN_A:   trun <= din;
          TREG1_A:  treg1 <= din;
          T01MOD_A: t01mod <= din;
          TREG3_A:  treg3 <= din;
          T23MOD_A: t23mod <= din;
          TFFCR_A: begin
            ffcr <= {din[5:4], din[1:0]};
            cmd1 <= din[3:2];
            cmd3 <= din[7:6];
          end
          default: ;
        endcase
    end
`ifdef JT95C061_TREG_DBUF_EN
  logic [7:0] sh0, sh2;
  // a write coinciding with the reload pulse bypasses the shadow
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sh0 <= '0;
      sh2 <= '0;
      treg0 <= '0;
      treg2 <= '0;
    end else begin
      if (over[0] && t01mod[4]) treg0 <= sh0;
      if (over[2] && t23mod[4]) treg2 <= sh2;
      if (wr && addr == TREG0_A) begin
        sh0 <= din;
        if (!t01mod[4] || over[0]) treg0 <= din;
      end
      if (wr && addr == TREG2_A) begin
        sh2 <= din;
        if (!t23mod[4] || over[2]) treg2 <= din;
      end
    end
  assign treg0_rd = t01mod[4] ? sh0 : treg0;
  assign treg2_rd = t23mod[4] ? sh2 : treg2;
`else
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      treg0 <= '0;
      treg2 <= '0;
    end else begin
      if (wr && addr == TREG0_A) treg0 <= din;
      if (wr && addr == TREG2_A) treg2 <= din;
    end
  assign treg0_rd = treg0;
  assign treg2_rd = treg2;
`endif
  always_comb begin
    dout = 8'h00;
    case (addr)
      TRUN_A:   dout = trun;
      TREG0_A:  dout = treg0_rd;
      TREG1_A:  dout = treg1;
      T01MOD_A: dout = t01mod;
      TFFCR_A:  dout = {FF_NONE, ffcr[3:2], FF_NONE, ffcr[1:0]};
      TREG2_A:  dout = treg2_rd;
      TREG3_A:  dout = treg3;
      T23MOD_A: dout = t23mod;
      default:  dout = 8'h00;
    endcase
  end
  assign run    = trun[3:0] & {4{trun[7]}};
  assign muxsel = {t23mod[3:0], t01mod[3:0]};
  assign cntmax = {treg3, treg2, treg1, treg0};
  assign muxin  = {pt256, pt16, pt1, over[2], pt16, pt4, pt1, tin2,
                   pt256, pt16, pt1, over[0], pt16, pt4, pt1, tin0};
  assign ffc1   = {cmd1, ffcr[1:0]};
  assign ffc3   = {cmd3, ffcr[3:2]};
endmodule

// File: tb/tb_jt95c061_tmr_ctrl.sv
// tb_jt95c061_tmr_ctrl: table vectors, corner sequences and random traffic against a register-map model
module tb_jt95c061_tmr_ctrl;
  logic rst = 1'b1, clk = 1'b0, cen = 1'b0, halt = 1'b0, cs = 1'b0, we = 1'b0;
  logic tin0 = 1'b0, tin2 = 1'b0;
  logic [3:0] addr = '0, over = '0;
  logic [7:0] din = '0, dout;
  logic [15:0] muxin;
  logic [7:0] muxsel;
  logic [31:0] cntmax;
  logic [3:0] run, ffc1, ffc3;

  jt95c061_tmr_ctrl dut (
    .rst(rst), .clk(clk), .cen(cen), .halt(halt), .cs(cs), .we(we), .addr(addr),
    .din(din), .dout(dout), .tin0(tin0), .tin2(tin2), .over(over), .muxin(muxin),
    .muxsel(muxsel), .cntmax(cntmax), .run(run), .ffc1(ffc1), .ffc3(ffc3)
  );

  always #5 clk = ~clk;

  int passed = 0, total = 0;
  logic [7:0] mreg [16];
  logic [7:0] sh0, sh2;
  int pre;
  logic [1:0] p1, p3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mreg[i] = 8'h00;
    sh0 = 8'h00;
    sh2 = 8'h00;
    pre = 0;
    p1 = 2'b11;
    p3 = 2'b11;
  endtask

  function automatic logic [7:0] mread(input logic [3:0] a);
`ifdef JT95C061_TREG_DBUF_EN
    if (a == 4'h2 && mreg[4][4]) return sh0;
    if (a == 4'h6 && mreg[8][4]) return sh2;
`endif
    if (a == 4'h5) return mreg[5] | 8'hCC;
    if (a inside {4'h0, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'h8}) return mreg[a];
    return 8'h00;
  endfunction

  // one clock edge of the register map, using the register values from before the edge
  task automatic mstep(input logic c, w, input logic [3:0] a, input logic [7:0] d,
                       input logic ce, h, input logic [3:0] ov);
    logic f0, f2;
    f0 = mreg[4][4];
    f2 = mreg[8][4];
    if (!mreg[0][7]) pre = 0;
    else if (ce && !h) pre = (pre + 1) % 2048;
    if (!h) begin
      p1 = 2'b11;
      p3 = 2'b11;
    end
`ifdef JT95C061_TREG_DBUF_EN
    if (ov[0] && f0) mreg[2] = sh0;
    if (ov[2] && f2) mreg[6] = sh2;
`endif
    if (c && w) begin
      if (a == 4'h5) begin
        mreg[5] = d & 8'h33;
        p1 = d[3:2];
        p3 = d[7:6];
      end else if (a inside {4'h0, 4'h3, 4'h4, 4'h7, 4'h8}) mreg[a] = d;
      else if (a == 4'h2) begin
`ifdef JT95C061_TREG_DBUF_EN
        sh0 = d;
        if (!f0 || ov[0]) mreg[2] = d;
`else
        mreg[2] = d;
`endif
      end else if (a == 4'h6) begin
`ifdef JT95C061_TREG_DBUF_EN
        sh2 = d;
        if (!f2 || ov[2]) mreg[6] = d;
`else
        mreg[6] = d;
`endif
      end
    end
  endtask

  task automatic check_all();
    logic q1, q4, q16, q256;
    q1 = ((pre / 4) % 2) == 1;
    q4 = ((pre / 16) % 2) == 1;
    q16 = ((pre / 64) % 2) == 1;
    q256 = ((pre / 1024) % 2) == 1;
    chk("dout", dout, mread(addr));
    chk("run", run, mreg[0][3:0] & {4{mreg[0][7]}});
    chk("muxsel", muxsel, {mreg[8][3:0], mreg[4][3:0]});
    chk("cntmax", cntmax, {mreg[7], mreg[6], mreg[3], mreg[2]});
    chk("muxin", muxin, {q256, q16, q1, over[2], q16, q4, q1, tin2,
                         q256, q16, q1, over[0], q16, q4, q1, tin0});
    chk("ffc1", ffc1, {p1, mreg[5][1:0]});
    chk("ffc3", ffc3, {p3, mreg[5][5:4]});
  endtask

  task automatic step(input logic c, w, input logic [3:0] a, input logic [7:0] d,
                      input logic ce, h, ti0, ti2, input logic [3:0] ov);
    cs = c; we = w; addr = a; din = d; cen = ce; halt = h; tin0 = ti0; tin2 = ti2; over = ov;
    @(posedge clk);
    #1;
    mstep(c, w, a, d, ce, h, ov);
    check_all();
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic ce, h, input logic [3:0] ov);
    step(1'b1, 1'b1, a, d, ce, h, 1'b0, 1'b0, ov);
  endtask

  task automatic idle(input logic ce, h, input logic [3:0] ov);
    step(1'b0, 1'b0, addr, 8'h00, ce, h, 1'b0, 1'b0, ov);
  endtask

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl [8];

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int n, t_first, t_second;
    logic prev;
    tbl[0] = '{4'h0, 8'h81, 8'h81};
    tbl[1] = '{4'h5, 8'h0B, 8'hCF};
    tbl[2] = '{4'h4, 8'h06, 8'h06};
    tbl[3] = '{4'h3, 8'h00, 8'h00};
    tbl[4] = '{4'h2, 8'h05, 8'h05};
    tbl[5] = '{4'hF, 8'h55, 8'h00};
    tbl[6] = '{4'h1, 8'h33, 8'h00};
    tbl[7] = '{4'h8, 8'h9D, 8'h9D};
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_trun", dout, 8'h00);
    addr = 4'h5;
    #1;
    chk("rst_tffcr", dout, 8'hCC);
    chk("rst_ffc1", ffc1, 4'b1100);
    chk("rst_ffc3", ffc3, 4'b1100);
    chk("rst_run", run, 4'b0000);
    check_all();

    // prescaler start-up and pt256 period
    wr(4'h0, 8'h81, 1'b1, 1'b0, 4'h0);
    chk("run_en", run, 4'b0001);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      idle(1'b1, 1'b0, 4'h0);
      n++;
      if (muxin[1]) break;
    end
    chk("pt1_first", n, 4);
    t_first = -1;
    t_second = -1;
    prev = muxin[7];
    for (int i = 0; i < 5000 && t_second < 0; i++) begin
      idle(1'b1, 1'b0, 4'h0);
      if (muxin[7] && !prev) begin
        if (t_first < 0) t_first = i;
        else t_second = i;
      end
      prev = muxin[7];
    end
    chk("pt256_period", t_second - t_first, 2048);
    wr(4'h0, 8'h01, 1'b1, 1'b0, 4'h0);
    idle(1'b1, 1'b0, 4'h0);
    chk("taps_off", muxin & 16'hEEEE, 16'h0000);
    chk("run_off", run, 4'b0000);

    // FF command pulse, with and without halt
    wr(4'h5, 8'hCB, 1'b0, 1'b0, 4'h0);
    chk("ff_pulse1", ffc1, 4'b1011);
    chk("ff_quiet3", ffc3, 4'b1100);
    idle(1'b0, 1'b0, 4'h0);
    chk("ff_after1", ffc1, 4'b1111);
    wr(4'h5, 8'hCB, 1'b0, 1'b1, 4'h0);
    for (int i = 0; i < 5; i++) begin
      idle(1'b0, 1'b1, 4'h0);
      chk("ff_halt_hold", ffc1, 4'b1011);
    end
    halt = 1'b0;
    #2;
    chk("ff_nonhalt_cycle", ffc1, 4'b1011);
    idle(1'b0, 1'b0, 4'h0);
    chk("ff_halt_release", ffc1, 4'b1111);

    // reset in the middle of a pulse
    wr(4'h5, 8'h0B, 1'b0, 1'b0, 4'h0);
    chk("ff_pulse3", ffc3, 4'b0000);
    rst = 1'b1;
    #1;
    model_reset();
    chk("midrst_ffc1", ffc1, 4'b1100);
    chk("midrst_ffc3", ffc3, 4'b1100);
    @(posedge clk);
    #1 rst = 1'b0;
    check_all();

    // register map vectors
    foreach (tbl[i]) begin
      wr(tbl[i].a, tbl[i].d, 1'b0, 1'b0, 4'h0);
      step(1'b1, 1'b0, tbl[i].a, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      chk("tbl_read", dout, tbl[i].exp);
    end
    chk("muxsel_t0", muxsel[1:0], 2'd2);
    chk("muxsel_t1", muxsel[3:2], 2'd1);
    chk("cntmax_t1", cntmax[15:8], 8'h00);
    idle(1'b0, 1'b0, 4'h1);
    chk("muxin_over0_hi", muxin[4], 1'b1);
    idle(1'b0, 1'b0, 4'h0);
    chk("muxin_over0_lo", muxin[4], 1'b0);

    // TREG0 buffering around the over[0] reload
    wr(4'h4, 8'h00, 1'b0, 1'b0, 4'h0);
    wr(4'h2, 8'h05, 1'b0, 1'b0, 4'h0);
    wr(4'h4, 8'h10, 1'b0, 1'b0, 4'h0);
    wr(4'h2, 8'h10, 1'b0, 1'b0, 4'h0);
`ifdef JT95C061_TREG_DBUF_EN
    chk("dbuf_hold", cntmax[7:0], 8'h05);
    chk("dbuf_shadow_rd", dout, 8'h10);
    idle(1'b0, 1'b0, 4'h0);
    chk("dbuf_hold2", cntmax[7:0], 8'h05);
    idle(1'b0, 1'b0, 4'h1);
    chk("dbuf_load", cntmax[7:0], 8'h10);
`else
    chk("treg0_direct", cntmax[7:0], 8'h10);
    idle(1'b0, 1'b0, 4'h1);
    chk("treg0_over", cntmax[7:0], 8'h10);
`endif
    wr(4'h2, 8'h20, 1'b0, 1'b0, 4'h1);
    chk("treg0_write_on_over", cntmax[7:0], 8'h20);

    // random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
           8'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 4'($urandom));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
